// File: rtl/rr_trace_sched_pkg.sv
// Shared types for the trace-writer buffer scheduler: descriptor and
// completion records, the scheduler state encoding and a descriptor check.
package rr_trace_sched_pkg;

    // Records are sized for the widest supported address; narrower
    // instances zero-extend on the way in and slice on the way out.
    localparam int RR_ADDR_W = 64;
    localparam int RR_BITS_W = 64;

    typedef struct packed {
        logic [RR_ADDR_W-1:0] addr;
        logic [RR_ADDR_W-1:0] size;
    } rr_buf_desc_t;

    typedef struct packed {
        logic [RR_ADDR_W-1:0] addr;
        logic [RR_BITS_W-1:0] bits;
        logic                 flushed;
    } rr_buf_cpl_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        ACTIVE,
        CPL,
        STARVED
    } rr_sched_state_e;

    // A descriptor is unusable if it is empty or not beat aligned in either
    // base or length. beat_bytes is expected to be a power of two.
    function automatic logic desc_is_bad(input rr_buf_desc_t d, input int beat_bytes);
        logic [RR_ADDR_W-1:0] mask;
        mask = RR_ADDR_W'(beat_bytes - 1);
        return (d.size == '0) || ((d.addr & mask) != '0) || ((d.size & mask) != '0);
    endfunction

endpackage

// File: rtl/rr_desc_queue.sv
// Circular descriptor FIFO. Pointers carry one extra wrap bit so that full
// and empty are distinguished without a separate flag.
module rr_desc_queue
    import rr_trace_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  rr_buf_desc_t             push_data,
    input  logic                     pop,
    output rr_buf_desc_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);

    rr_buf_desc_t           mem [DEPTH];
    logic [IDX_W:0]         wr_ptr;
    logic [IDX_W:0]         rd_ptr;

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end

    // Pointer update; the caller never pushes when full nor pops when empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr[IDX_W-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == (IDX_W+1)'(DEPTH));

endmodule

// File: rtl/rr_trace_buf_sched.sv
// Host-buffer scheduler for the trace writer: queues host descriptors,
// hands them to the writer one at a time and reports each finished buffer.
module rr_trace_buf_sched
    import rr_trace_sched_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int DESC_DEPTH     = 4,
    parameter int BEAT_BYTES     = 64,
    parameter int SETTLE_CYCLES  = 2,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        enable,
    input  logic                        desc_valid,
    output logic                        desc_ready,
    input  logic [AXI_ADDR_WIDTH-1:0]   desc_addr,
    input  logic [AXI_ADDR_WIDTH-1:0]   desc_size,
    output logic [AXI_ADDR_WIDTH-1:0]   write_buf_addr,
    output logic [AXI_ADDR_WIDTH-1:0]   write_buf_size,
    output logic                        write_buf_update,
    input  logic                        write_interrupt,
    input  logic [63:0]                 record_bits,
    input  logic                        flush_req,
    input  logic                        writer_idle,
    output logic                        cpl_valid,
    input  logic                        cpl_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   cpl_addr,
    output logic [63:0]                 cpl_bits,
    output logic                        cpl_flushed,
    output logic [$clog2(DESC_DEPTH):0] desc_count,
    output logic [CNT_WIDTH-1:0]        stall_cycles,
    output logic                        err_bad_desc,
    output logic                        busy
);

    localparam int SETTLE_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES);

    rr_buf_desc_t                in_desc;
    rr_buf_desc_t                q_head;
    logic                        desc_bad;
    logic                        push_fire;
    logic                        q_push;
    logic                        q_pop;
    logic                        q_full;
    logic                        q_empty;
    logic                        can_load;
    logic                        cpl_fire;
    rr_sched_state_e             state_q;
    rr_sched_state_e             state_d;
    logic [SETTLE_W-1:0]         settle_cnt;
    logic [AXI_ADDR_WIDTH-1:0]   cur_addr;
    rr_buf_cpl_t                 cpl_q;

    // Widen the incoming descriptor into the shared record and classify it.
    always_comb begin
        in_desc      = '0;
        in_desc.addr = RR_ADDR_W'(desc_addr);
        in_desc.size = RR_ADDR_W'(desc_size);
        desc_bad     = desc_is_bad(in_desc, BEAT_BYTES);
    end

    // Ready is forced low while reset is held, otherwise it only tracks space.
    assign desc_ready = rstn & ~q_full;
    assign push_fire  = desc_valid & desc_ready;
    assign q_push     = push_fire & ~desc_bad;
    assign q_pop      = (state_q == LOAD);
    assign can_load   = enable & ~q_empty;
    assign cpl_fire   = cpl_valid & cpl_ready;

    rr_desc_queue #(
        .DEPTH (DESC_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rstn      (rstn),
        .push      (q_push),
        .push_data (in_desc),
        .pop       (q_pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (desc_count)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; exhaustion outranks flush when both are seen.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (can_load) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt <= SETTLE_W'(1)) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (write_interrupt || (flush_req && writer_idle)) begin
                    state_d = CPL;
                end
            end
            CPL: begin
                if (cpl_fire) begin
                    if (can_load) begin
                        state_d = LOAD;
                    end else if (!cpl_q.flushed) begin
                        state_d = STARVED;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            STARVED: begin
                if (can_load) begin
                    state_d = LOAD;
                end else if (!enable && flush_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Settle window that masks the writer's lagging interrupt after a load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            settle_cnt <= '0;
        end else if (state_q == LOAD) begin
            settle_cnt <= SETTLE_INIT;
        end else if (state_q == SETTLE && settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
        end
    end

    // Writer load interface: registered so the pulse lines up with LOAD.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            write_buf_addr   <= '0;
            write_buf_size   <= '0;
            write_buf_update <= 1'b0;
        end else begin
            write_buf_update <= (state_d == LOAD);
            if (state_d == LOAD) begin
                write_buf_addr <= q_head.addr[AXI_ADDR_WIDTH-1:0];
                write_buf_size <= q_head.size[AXI_ADDR_WIDTH-1:0];
            end
        end
    end

    // Remember which buffer the writer is filling for its completion record.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_addr <= '0;
        end else if (state_q == LOAD) begin
            cur_addr <= q_head.addr[AXI_ADDR_WIDTH-1:0];
        end
    end

    // Completion record: captured when ACTIVE closes, held until accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cpl_q     <= '0;
            cpl_valid <= 1'b0;
        end else if (state_q == ACTIVE && state_d == CPL) begin
            cpl_q.addr    <= RR_ADDR_W'(cur_addr);
            cpl_q.bits    <= record_bits;
            cpl_q.flushed <= ~write_interrupt;
            cpl_valid     <= 1'b1;
        end else if (cpl_fire) begin
            cpl_valid <= 1'b0;
        end
    end

    assign cpl_addr    = cpl_q.addr[AXI_ADDR_WIDTH-1:0];
    assign cpl_bits    = cpl_q.bits;
    assign cpl_flushed = cpl_q.flushed;

    // Saturating count of every cycle spent starved, including the cycle in
    // which the next load is chosen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles <= '0;
        end else if (state_q == STARVED && stall_cycles != {CNT_WIDTH{1'b1}}) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    // Sticky flag for descriptors that were accepted but discarded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_bad_desc <= 1'b0;
        end else if (push_fire && desc_bad) begin
            err_bad_desc <= 1'b1;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_rr_trace_buf_sched.sv
// Bench for rr_trace_buf_sched: directed scenarios followed by randomized
// traffic, all checked against a transaction-level model of the scheduler.
module tb_rr_trace_buf_sched;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] size;
    } tb_desc_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        desc_valid;
    logic        desc_ready;
    logic [63:0] desc_addr;
    logic [63:0] desc_size;
    logic [63:0] write_buf_addr;
    logic [63:0] write_buf_size;
    logic        write_buf_update;
    logic        write_interrupt;
    logic [63:0] record_bits;
    logic        flush_req;
    logic        writer_idle;
    logic        cpl_valid;
    logic        cpl_ready;
    logic [63:0] cpl_addr;
    logic [63:0] cpl_bits;
    logic        cpl_flushed;
    logic [2:0]  desc_count;
    logic [31:0] stall_cycles;
    logic        err_bad_desc;
    logic        busy;

    int          checks = 0;
    int          failures = 0;

    tb_desc_t    exp_q[$];
    int          model_count = 0;
    logic        model_err = 1'b0;
    logic [63:0] loaded_addr = '0;
    int          upd_count = 0;
    int          cpl_count = 0;
    logic        cpl_new = 1'b0;

    always #5 clk = ~clk;

    rr_trace_buf_sched dut (
        .clk              (clk),
        .rstn             (rstn),
        .enable           (enable),
        .desc_valid       (desc_valid),
        .desc_ready       (desc_ready),
        .desc_addr        (desc_addr),
        .desc_size        (desc_size),
        .write_buf_addr   (write_buf_addr),
        .write_buf_size   (write_buf_size),
        .write_buf_update (write_buf_update),
        .write_interrupt  (write_interrupt),
        .record_bits      (record_bits),
        .flush_req        (flush_req),
        .writer_idle      (writer_idle),
        .cpl_valid        (cpl_valid),
        .cpl_ready        (cpl_ready),
        .cpl_addr         (cpl_addr),
        .cpl_bits         (cpl_bits),
        .cpl_flushed      (cpl_flushed),
        .desc_count       (desc_count),
        .stall_cycles     (stall_cycles),
        .err_bad_desc     (err_bad_desc),
        .busy             (busy)
    );

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic isBad(input logic [63:0] a, input logic [63:0] s);
        return (s == 0) || ((a % 64) != 0) || ((s % 64) != 0);
    endfunction

    // Advance one clock, then compare what the DUT did against the model.
    task automatic applyStimulus();
        logic        p_push, p_upd, p_int, p_flush, p_cval, p_cfire, p_cflag;
        logic [63:0] p_addr, p_size, p_bits, p_caddr, p_cbits;
        tb_desc_t    d;
        p_push  = desc_valid && desc_ready;
        p_addr  = desc_addr;
        p_size  = desc_size;
        p_upd   = write_buf_update;
        p_int   = write_interrupt;
        p_flush = flush_req && writer_idle;
        p_bits  = record_bits;
        p_cval  = cpl_valid;
        p_cfire = cpl_valid && cpl_ready;
        p_caddr = cpl_addr;
        p_cbits = cpl_bits;
        p_cflag = cpl_flushed;
        @(posedge clk);
        #1;
        cpl_new = 1'b0;
        if (p_upd) model_count--;
        if (write_buf_update) begin
            upd_count++;
            checkOutput("upd_width", p_upd, 0);
            checkOutput("upd_while_cpl", cpl_valid, 0);
            checkOutput("upd_has_desc", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                d = exp_q.pop_front();
                checkOutput("upd_addr", write_buf_addr, d.addr);
                checkOutput("upd_size", write_buf_size, d.size);
                loaded_addr = d.addr;
            end
        end
        if (p_push) begin
            if (isBad(p_addr, p_size)) begin
                model_err = 1'b1;
            end else begin
                d.addr = p_addr;
                d.size = p_size;
                exp_q.push_back(d);
                model_count++;
            end
        end
        if (p_cval && !p_cfire) begin
            checkOutput("cpl_hold_valid", cpl_valid, 1);
            checkOutput("cpl_hold_payload", {cpl_addr, cpl_bits}, {p_caddr, p_cbits});
            checkOutput("cpl_hold_flag", cpl_flushed, p_cflag);
        end else if (cpl_valid) begin
            cpl_new = 1'b1;
            cpl_count++;
            checkOutput("cpl_trigger", p_int | p_flush, 1);
            checkOutput("cpl_addr", cpl_addr, loaded_addr);
            checkOutput("cpl_bits", cpl_bits, p_bits);
            checkOutput("cpl_flushed", cpl_flushed, !p_int);
        end
        checkOutput("desc_count", desc_count, model_count);
        checkOutput("err_bad_desc", err_bad_desc, model_err);
    endtask

    task automatic pushDesc(input logic [63:0] a, input logic [63:0] s);
        desc_valid = 1'b1;
        desc_addr  = a;
        desc_size  = s;
        applyStimulus();
        desc_valid = 1'b0;
    endtask

    task automatic waitUpdate(input string tag, input int limit);
        int n;
        n = 0;
        while (!write_buf_update && n < limit) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, write_buf_update, 1);
    endtask

    task automatic waitCpl(input string tag, input int limit);
        int n;
        n = 0;
        while (!cpl_valid && n < limit) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, cpl_valid, 1);
    endtask

    task automatic acceptCpl();
        cpl_ready = 1'b1;
        applyStimulus();
        cpl_ready = 1'b0;
    endtask

    task automatic doReset();
        rstn            = 1'b0;
        enable          = 1'b0;
        desc_valid      = 1'b0;
        desc_addr       = '0;
        desc_size       = '0;
        write_interrupt = 1'b0;
        record_bits     = '0;
        flush_req       = 1'b0;
        writer_idle     = 1'b0;
        cpl_ready       = 1'b0;
        #1;
        checkOutput("rst_cpl_valid", cpl_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_desc_ready", desc_ready, 0);
        checkOutput("rst_desc_count", desc_count, 0);
        checkOutput("rst_update", write_buf_update, 0);
        checkOutput("rst_stall", stall_cycles, 0);
        checkOutput("rst_err", err_bad_desc, 0);
        checkOutput("rst_buf_addr", write_buf_addr, 0);
        exp_q.delete();
        model_count = 0;
        model_err   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        checkOutput("rst_release_ready", desc_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          ups;
        int          cpls;
        int          mode;
        int          wr_wait;
        logic [63:0] a;
        logic [63:0] s;

        doReset();
        enable = 1'b1;

        // Single descriptor: one load pulse, queue drains.
        pushDesc(64'h1000, 64'h80);
        checkOutput("t1_count_one", desc_count, 1);
        waitUpdate("t1_update", 4);
        checkOutput("t1_addr", write_buf_addr, 64'h1000);
        checkOutput("t1_size", write_buf_size, 64'h80);
        checkOutput("t1_busy", busy, 1);
        applyStimulus();
        checkOutput("t1_count_zero", desc_count, 0);
        checkOutput("t1_pulse_once", write_buf_update, 0);

        // Exhaustion with a second descriptor waiting: direct reload.
        pushDesc(64'h3000, 64'h100);
        write_interrupt = 1'b1;
        record_bits     = 64'd1024;
        waitCpl("t2_cpl", 10);
        checkOutput("t2_cpl_addr", cpl_addr, 64'h1000);
        checkOutput("t2_cpl_bits", cpl_bits, 64'd1024);
        checkOutput("t2_cpl_flushed", cpl_flushed, 0);
        write_interrupt = 1'b0;
        acceptCpl();
        checkOutput("t2_direct_load", write_buf_update, 1);
        checkOutput("t2_load_addr", write_buf_addr, 64'h3000);
        checkOutput("t2_no_stall", stall_cycles, 0);

        // Exhaustion with an empty queue: 8 idle cycles, the push cycle and
        // the load-decision cycle are all counted as starved.
        repeat (3) applyStimulus();
        write_interrupt = 1'b1;
        record_bits     = 64'd2048;
        waitCpl("t3_cpl", 10);
        write_interrupt = 1'b0;
        acceptCpl();
        repeat (8) applyStimulus();
        checkOutput("t3_stall_mid", stall_cycles, 8);
        checkOutput("t3_busy_starved", busy, 1);
        pushDesc(64'h2000, 64'h40);
        applyStimulus();
        checkOutput("t3_load", write_buf_update, 1);
        checkOutput("t3_load_addr", write_buf_addr, 64'h2000);
        checkOutput("t3_stall_final", stall_cycles, 10);

        // Malformed descriptors are consumed but dropped.
        ups = upd_count;
        checkOutput("t4_ready_a", desc_ready, 1);
        pushDesc(64'h4000, 64'h30);
        checkOutput("t4_ready_b", desc_ready, 1);
        pushDesc(64'h1010, 64'h40);
        applyStimulus();
        checkOutput("t4_err", err_bad_desc, 1);
        checkOutput("t4_count", desc_count, 0);
        checkOutput("t4_no_update", upd_count, ups);

        // Flush is held off until the writer drains.
        flush_req   = 1'b1;
        writer_idle = 1'b0;
        repeat (5) applyStimulus();
        checkOutput("t5_no_early_cpl", cpl_valid, 0);
        writer_idle = 1'b1;
        applyStimulus();
        checkOutput("t5_cpl", cpl_valid, 1);
        checkOutput("t5_flushed", cpl_flushed, 1);
        checkOutput("t5_addr", cpl_addr, 64'h2000);
        flush_req   = 1'b0;
        writer_idle = 1'b0;
        acceptCpl();
        applyStimulus();
        checkOutput("t5_idle", busy, 0);

        // Interrupt and flush during LOAD and SETTLE are ignored.
        cpls = cpl_count;
        pushDesc(64'h5000, 64'h80);
        waitUpdate("t6_update", 4);
        write_interrupt = 1'b1;
        flush_req       = 1'b1;
        writer_idle     = 1'b1;
        repeat (3) applyStimulus();
        write_interrupt = 1'b0;
        flush_req       = 1'b0;
        writer_idle     = 1'b0;
        repeat (4) applyStimulus();
        checkOutput("t6_no_cpl", cpl_valid, 0);
        checkOutput("t6_cpl_count", cpl_count, cpls);

        // Fill the queue with loading disabled; the fifth push must stall.
        enable = 1'b0;
        ups    = upd_count;
        for (int i = 0; i < 4; i++) pushDesc(64'h6000 + 64'(i) * 64'h40, 64'h40);
        checkOutput("t7_full_count", desc_count, 4);
        checkOutput("t7_not_ready", desc_ready, 0);
        pushDesc(64'h7000, 64'h40);
        checkOutput("t7_blocked", desc_count, 4);
        checkOutput("t7_no_update", upd_count, ups);

        // Reset in the middle of a pending completion.
        write_interrupt = 1'b1;
        waitCpl("t8_cpl", 10);
        write_interrupt = 1'b0;
        applyStimulus();
        doReset();
        repeat (3) applyStimulus();
        checkOutput("t8_no_cpl_after", cpl_valid, 0);

        // Randomized traffic with the bench acting as the writer.
        wr_wait = -1;
        cpls    = cpl_count;
        for (int t = 0; t < 3000; t++) begin
            enable      = ($urandom_range(0, 15) != 0);
            desc_valid  = ($urandom_range(0, 2) == 0);
            a           = 64'($urandom_range(0, 1023)) * 64;
            s           = 64'($urandom_range(1, 8)) * 64;
            case ($urandom_range(0, 15))
                0:       a = a + 64'h10;
                1:       s = 64'h0;
                2:       s = 64'h30;
                default: ;
            endcase
            desc_addr   = a;
            desc_size   = s;
            cpl_ready   = $urandom_range(0, 1);
            writer_idle = $urandom_range(0, 1);
            record_bits = {$urandom, $urandom};
            applyStimulus();
            if (write_buf_update) begin
                wr_wait         = $urandom_range(1, 6);
                write_interrupt = 1'b0;
                flush_req       = 1'b0;
            end else if (cpl_new) begin
                write_interrupt = 1'b0;
                flush_req       = 1'b0;
                wr_wait         = -1;
            end else if (wr_wait > 0) begin
                wr_wait--;
            end else if (wr_wait == 0) begin
                mode            = $urandom_range(0, 2);
                write_interrupt = (mode != 1);
                flush_req       = (mode != 0);
                wr_wait         = -1;
            end
        end
        checkOutput("rand_activity", (cpl_count - cpls) > 20, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_trace_buf_sched.md
Name: rr_trace_buf_sched

Overview:
- Host-buffer scheduler for the write-only trace writer.
- Queues host-supplied buffer descriptors (addr, size) and hands them to the writer one at a time via write_buf_addr/size/update.
- Detects buffer exhaustion from the writer's write_interrupt and reports each finished buffer (addr, recorded bits) on a completion handshake.
- Sits between the CSR/host-control logic and the trace writer; multi-buffer recording then proceeds without per-buffer software round trips.

Parameters:
- AXI_ADDR_WIDTH, 64: width of buffer addresses and sizes.
- DESC_DEPTH, 4: descriptor queue entries; power of 2, ≥2.
- BEAT_BYTES, 64: writer beat size. Descriptor addr and size must be multiples of this.
- SETTLE_CYCLES, 2: cycles after an update pulse during which write_interrupt is ignored. Covers the writer's registered interrupt lag.
- CNT_WIDTH, 32: width of the stall counter.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- enable  in  1  when low, no new descriptor is loaded; an active buffer runs on
- desc_valid  in  1  descriptor push valid
- desc_ready  out  1  descriptor push ready (queue not full)
- desc_addr  in  AXI_ADDR_WIDTH  buffer base address
- desc_size  in  AXI_ADDR_WIDTH  buffer size in bytes
- write_buf_addr  out  AXI_ADDR_WIDTH  to writer
- write_buf_size  out  AXI_ADDR_WIDTH  to writer
- write_buf_update  out  1  one-cycle load pulse to writer
- write_interrupt  in  1  writer: current buffer exhausted
- record_bits  in  64  writer: bits written into current buffer
- flush_req  in  1  level; close current buffer early (only while writer idle)
- writer_idle  in  1  writer output FIFO empty, no AXI write outstanding
- cpl_valid  out  1  completion valid
- cpl_ready  in  1  completion accept
- cpl_addr  out  AXI_ADDR_WIDTH  completed buffer base
- cpl_bits  out  64  record_bits sampled at completion
- cpl_flushed  out  1  completion caused by flush, not exhaustion
- desc_count  out  $clog2(DESC_DEPTH)+1  queued descriptors
- stall_cycles  out  CNT_WIDTH  cycles spent in STARVED
- err_bad_desc  out  1  sticky; a malformed descriptor was dropped
- busy  out  1  state is not IDLE

Behaviour:
- Reset (async assert, sync deassert assumed upstream): all outputs 0; desc_ready is 0 only during reset; state IDLE; queue empty.
- Queue:
  - Circular FIFO with pointers one bit wider than log2(DESC_DEPTH).
  - Push when desc_valid&desc_ready. Pop occurs only in LOAD.
  - A simultaneous push and pop at full is not possible, because desc_ready is low when full.
- Descriptor check at push:
  - A descriptor is malformed if size==0, or addr%BEAT_BYTES!=0, or size%BEAT_BYTES!=0.
  - A malformed descriptor is consumed (handshake completes) but not enqueued, and err_bad_desc is set. err_bad_desc clears only on reset.
- States:
  - IDLE: go to LOAD when enable and queue non-empty.
  - LOAD:
    - Drive write_buf_addr/size from the queue head and pulse write_buf_update for exactly 1 cycle.
    - Latch the head addr into cur_addr and pop.
    - Go to SETTLE with settle_cnt=SETTLE_CYCLES.
    - write_buf_addr/size hold their value until the next LOAD.
  - SETTLE: decrement settle_cnt and ignore write_interrupt; go to ACTIVE when the count reaches 0.
  - ACTIVE, priority order:
    1. write_interrupt → CPL with flushed=0.
    2. flush_req&writer_idle → CPL with flushed=1.
    3. Otherwise hold.
  - CPL:
    - On entry, register cpl_addr=cur_addr, cpl_bits=record_bits (sampled on the transition cycle, before any update) and cpl_flushed, and assert cpl_valid.
    - Hold until cpl_valid&cpl_ready.
    - On the accept cycle, choose the next state:
      - LOAD if enable and queue non-empty;
      - else STARVED if not flushed;
      - else IDLE.
  - STARVED:
    - The writer is stalled with curr==end (its backpressure propagates upstream).
    - stall_cycles increments each cycle, saturating at all-ones.
    - Go to LOAD when enable and queue non-empty. If enable is low and flush_req is seen, go to IDLE.
- Output timing:
  - cpl_valid is registered and follows AXI valid rules: once high, its payload is stable until accepted.
  - write_buf_update never asserts while cpl_valid=1.
- Boundary behaviour:
  - Exhaustion and flush in the same cycle: this is exhaustion, with flushed=0.
  - flush_req in SETTLE, LOAD or CPL is ignored (it is a level and is re-evaluated in ACTIVE).
  - A descriptor pushed in the same cycle as an IDLE→LOAD evaluation is not visible until the next cycle.
  - Reset mid-operation: state returns to IDLE, the queue is discarded and no completion is emitted.

Decomposition:
- Shared package rr_trace_sched_pkg holds:
  - typedef rr_buf_desc_t {addr, size};
  - typedef rr_buf_cpl_t {addr, bits, flushed};
  - enum rr_sched_state_e {IDLE, LOAD, SETTLE, ACTIVE, CPL, STARVED}.
- One sub-module, rr_desc_queue: parameterised FIFO of rr_buf_desc_t with count output. The FSM stays in the top.

Test Plan:
- Push (0x1000,0x80), enable=1 → write_buf_update pulses once with addr 0x1000, size 0x80; busy=1; desc_count goes 1→0.
- Drive write_interrupt and hold record_bits=1024, with one more descriptor queued → cpl (0x1000,1024,0); after cpl_ready, LOAD with the second descriptor and no STARVED cycles.
- Exhaust with an empty queue for 10 cycles, then push (0x2000,0x40) → stall_cycles=10 or 11 (document the exact count); then a LOAD pulse with addr 0x2000.
- Push size 0x30, then addr 0x1010 → both handshakes accepted, err_bad_desc=1, desc_count=0, no update pulse.
- In ACTIVE, flush_req=1 with writer_idle=0 for 5 cycles, then writer_idle=1 → a single completion with flushed=1 after writer_idle rises; state goes to IDLE.
- Assert write_interrupt during the 2 SETTLE cycles → no completion; push 4 descriptors → desc_ready=0 and a 5th push is blocked; assert rstn low mid-CPL → cpl_valid=0 immediately.
